// File: rtl/ibex_mem_arbiter.sv
// Shares one single-port SRAM between the Ibex instruction and data ports.
// Provides bounded-fairness arbitration, address-range errors and per-port one-cycle responses.
module ibex_mem_arbiter #(
    parameter logic [31:0] MemStart      = 32'h0000_0000,
    parameter int unsigned MemSize       = 8192,
    parameter int unsigned InstrBurstMax = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [31:0] AddrMask = ~(32'(MemSize) - 32'd1);
    localparam logic [3:0]  BurstMax = 4'(InstrBurstMax);

    logic [3:0]  r_burst_cnt;
    logic        r_rsp_valid;
    logic        r_rsp_port;
    logic        r_rsp_err;
    logic        r_rsp_rd;

    logic        w_instr_in_range;
    logic        w_data_in_range;
    logic        w_data_win;
    logic        w_instr_win;
    logic        w_grant;
    logic [31:0] w_instr_off;
    logic [31:0] w_data_off;
    logic [3:0]  w_burst_cnt_nxt;

    assign w_instr_in_range = (instr_addr_i & AddrMask) == MemStart;
    assign w_data_in_range  = (data_addr_i & AddrMask) == MemStart;
    assign w_instr_off      = instr_addr_i - MemStart;
    assign w_data_off       = data_addr_i - MemStart;

    // NOTE: grants are gated by rst_ni so that nothing (including an SRAM write) escapes while reset is held.
    assign w_data_win  = rst_ni & data_req_i & (~instr_req_i | (r_burst_cnt == BurstMax));
    assign w_instr_win = rst_ni & instr_req_i & ~w_data_win;
    assign w_grant     = w_instr_win | w_data_win;

    assign instr_gnt_o = w_instr_win;
    assign data_gnt_o  = w_data_win;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (w_instr_win && w_instr_in_range) begin
            mem_req_o  = 1'b1;
            mem_be_o   = 4'hF;
            mem_addr_o = {w_instr_off[31:2], 2'b00};
        end else if (w_data_win && w_data_in_range) begin
            mem_req_o   = 1'b1;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = {w_data_off[31:2], 2'b00};
            mem_wdata_o = data_wdata_i;
        end
    end

    // Instruction streak length while data waits; any data grant or idle data port resets it.
    always_comb begin
        w_burst_cnt_nxt = r_burst_cnt;
        if (!data_req_i || w_data_win) begin
            w_burst_cnt_nxt = 4'd0;
        end else if (w_instr_win && (r_burst_cnt < BurstMax)) begin
            w_burst_cnt_nxt = r_burst_cnt + 4'd1;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_burst_cnt <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rd    <= 1'b0;
        end else begin
            r_burst_cnt <= w_burst_cnt_nxt;
            r_rsp_valid <= w_grant;
            r_rsp_port  <= w_data_win;
            r_rsp_err   <= w_data_win ? ~w_data_in_range : (w_instr_win & ~w_instr_in_range);
            r_rsp_rd    <= w_instr_win | (w_data_win & ~data_we_i);
        end
    end

    assign instr_rvalid_o = r_rsp_valid & ~r_rsp_port;
    assign data_rvalid_o  = r_rsp_valid & r_rsp_port;
    assign instr_err_o    = instr_rvalid_o & r_rsp_err;
    assign data_err_o     = data_rvalid_o & r_rsp_err;
    assign instr_rdata_o  = (instr_rvalid_o && !r_rsp_err && r_rsp_rd) ? mem_rdata_i : 32'h0;
    assign data_rdata_o   = (data_rvalid_o && !r_rsp_err && r_rsp_rd) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed bench for ibex_mem_arbiter with a behavioural single-port SRAM model.
module tb_ibex_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'h0;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] sram [2048];
    logic        preload = 1'b1;
    logic        watch_drv = 1'b0;
    logic        saw_drv = 1'b0;

    always #5 clk_i = ~clk_i;

    ibex_mem_arbiter #(
        .MemStart     (32'h0000_0000),
        .MemSize      (8192),
        .InstrBurstMax(4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_err_o   (instr_err_o),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    // SRAM model: byte-enabled write, registered read data one cycle after the strobe.
    always @(posedge clk_i) begin
        if (preload) begin
            sram[32]   <= 32'hDEAD_BEEF;
            sram[64]   <= 32'hAABB_CCDD;
            sram[2047] <= 32'h0BAD_F00D;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o[12:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o[12:2]];
            end
        end
    end

    always @(data_rvalid_o) if (watch_drv && data_rvalid_o) saw_drv = 1'b1;

    typedef struct {
        string       name;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [71:0] e_gnt;   // {igt, dgt, mreq, mwe, mbe, maddr, mwdata}
        logic [3:0]  e_flags; // {irvalid, drvalid, ierr, derr}
        logic [63:0] e_rdata; // {instr_rdata, data_rdata}
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
    endtask

    function automatic logic [159:0] all_outs();
        return 160'({instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
                     data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o});
    endfunction

    initial begin
        vecs[0] = '{"fetch_80", 1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    {4'b1010, 4'hF, 32'h80, 32'h0}, 4'b1000, {32'hDEAD_BEEF, 32'h0}};
        vecs[1] = '{"store_100", 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'h1234_5678,
                    {4'b0111, 4'b0011, 32'h100, 32'h1234_5678}, 4'b0100, 64'h0};
        vecs[2] = '{"load_100", 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0,
                    {4'b0110, 4'hF, 32'h100, 32'h0}, 4'b0100, {32'h0, 32'hAABB_5678}};
        vecs[3] = '{"load_2000", 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0,
                    {4'b0100, 4'h0, 32'h0, 32'h0}, 4'b0101, 64'h0};
        vecs[4] = '{"load_1ffc", 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1FFC, 32'h0,
                    {4'b0110, 4'hF, 32'h1FFC, 32'h0}, 4'b0100, {32'h0, 32'h0BAD_F00D}};
        vecs[5] = '{"fetch_wrap", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    {4'b1000, 4'h0, 32'h0, 32'h0}, 4'b1010, 64'h0};
        vecs[6] = '{"both_req", 1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0,
                    {4'b1010, 4'hF, 32'h80, 32'h0}, 4'b1000, {32'hDEAD_BEEF, 32'h0}};
        vecs[7] = '{"store_3000", 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h3000, 32'h55,
                    {4'b0100, 4'h0, 32'h0, 32'h0}, 4'b0101, 64'h0};

        idle();
        rst_ni = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        data_req_i  = 1'b1; data_addr_i  = 32'h100; data_be_i = 4'hF;
        repeat (2) @(negedge clk_i);
        check("reset_outputs_zero", all_outs(), 160'h0);
        preload = 1'b0;
        idle();
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            instr_req_i  = vecs[i].ireq;
            instr_addr_i = vecs[i].iaddr;
            data_req_i   = vecs[i].dreq;
            data_we_i    = vecs[i].dwe;
            data_be_i    = vecs[i].dbe;
            data_addr_i  = vecs[i].daddr;
            data_wdata_i = vecs[i].dwdata;
            #2;
            check({vecs[i].name, "_grant"},
                  160'({instr_gnt_o, data_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}),
                  160'(vecs[i].e_gnt));
            @(posedge clk_i);
            #1 idle();
            @(negedge clk_i);
            check({vecs[i].name, "_rsp"}, 160'({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}),
                  160'(vecs[i].e_flags));
            check({vecs[i].name, "_rdata"}, 160'({instr_rdata_o, data_rdata_o}), 160'(vecs[i].e_rdata));
        end

        // Both ports saturated: four fetches then one data access, repeating.
        @(negedge clk_i);
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        data_req_i  = 1'b1; data_addr_i  = 32'h100; data_be_i = 4'hF;
        for (int c = 0; c < 10; c++) begin
            #2;
            check($sformatf("burst_gnt_%0d", c), 160'({instr_gnt_o, data_gnt_o}),
                  (c % 5 == 4) ? 160'b01 : 160'b10);
            check($sformatf("burst_cnt_%0d", c), 160'(dut.r_burst_cnt), 160'(c % 5));
            @(negedge clk_i);
        end
        idle();

        // Reset between a data grant and its response.
        repeat (2) @(negedge clk_i);
        watch_drv = 1'b1;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h100;
        #2 check("rst_seq_dgnt", 160'(data_gnt_o), 160'b1);
        #1 rst_ni = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        #1 check("rst_seq_outs_zero", all_outs(), 160'h0);
        repeat (2) @(negedge clk_i);
        check("rst_seq_outs_zero_held", all_outs(), 160'h0);
        idle();
        rst_ni = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        #2;
        check("post_rst_cnt", 160'(dut.r_burst_cnt), 160'h0);
        check("post_rst_igrant", 160'({instr_gnt_o, data_gnt_o, mem_req_o}), 160'b101);
        @(posedge clk_i);
        #1 idle();
        @(negedge clk_i);
        check("post_rst_fetch", 160'({instr_rvalid_o, instr_err_o, instr_rdata_o}), 160'({2'b10, 32'hDEAD_BEEF}));
        repeat (2) @(negedge clk_i);
        check("no_dropped_drvalid", 160'(saw_drv), 160'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
